// File: rtl/enemy_fire_scheduler_pkg.sv
// enemy_fire_scheduler_pkg: shared enemy/slot counts, timing defaults, FSM state encoding and LFSR seed
package enemy_fire_scheduler_pkg;
  localparam int DEF_N_ENEMIES = 20;
  localparam int DEF_N_SLOTS = 4;
  localparam int DEF_FIRE_PERIOD = 60;
  localparam int DEF_MIN_PERIOD = 15;
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  typedef enum logic [1:0] {
    ST_COOLDOWN = 2'd0,
    ST_SCAN = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;
endpackage

// File: rtl/enemy_fire_scheduler_lfsr8.sv
// lfsr8: 8-bit Fibonacci LFSR (taps 8,6,5,4) seeded with 8'hA5, advances when en is high
//   CLOCK_50 clock, reset async active-high, en step enable, q current state
module lfsr8 import enemy_fire_scheduler_pkg::*; (
  input logic CLOCK_50,
  input logic reset,
  input logic en,
  output logic [7:0] q
);
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) q <= LFSR_SEED;
    else if (en) q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
endmodule

// File: rtl/enemy_fire_scheduler.sv
// enemy_fire_scheduler: picks when an enemy fires, which living enemy shoots and which free slot carries it
//   CLOCK_50/reset clock and async active-high reset; pausa freezes; perdeu aborts to cooldown
//   frame_tick per-frame pulse; alive enemy-alive vector; slot_busy projectile slots in flight
//   fire_valid/fire_ready shot handshake carrying fire_enemy and fire_slot; wave_clear pulses on an empty scan
module enemy_fire_scheduler import enemy_fire_scheduler_pkg::*; #(
  parameter int N_ENEMIES = DEF_N_ENEMIES,
  parameter int N_SLOTS = DEF_N_SLOTS,
  parameter int FIRE_PERIOD = DEF_FIRE_PERIOD,
  parameter int MIN_PERIOD = DEF_MIN_PERIOD,
  parameter bit RANDOMIZE = 1'b1,
  localparam int EW = $clog2(N_ENEMIES),
  localparam int SW = $clog2(N_SLOTS),
  localparam int CW = $clog2(FIRE_PERIOD + 1),
  localparam int PW = $clog2(N_ENEMIES + 1)
) (
  input logic CLOCK_50,
  input logic reset,
  input logic pausa,
  input logic perdeu,
  input logic frame_tick,
  input logic [N_ENEMIES-1:0] alive,
  input logic [N_SLOTS-1:0] slot_busy,
  output logic fire_valid,
  input logic fire_ready,
  output logic [EW-1:0] fire_enemy,
  output logic [SW-1:0] fire_slot,
  output logic wave_clear
);
  state_t state_q, state_d;
  logic [CW-1:0] cd_q, cd_d, period;
  logic [EW-1:0] ptr_q, ptr_d, scan_q, scan_d, cnt_q, cnt_d, enemy_q, enemy_d, start;
  logic [SW-1:0] slot_q, slot_d, free_idx;
  logic wclear_q, wclear_d, any_free, unused_lfsr;
  logic [PW-1:0] pop;
  logic [31:0] dead;
  logic [7:0] lfsr;
  logic [2:0] offset;
  lfsr8 u_lfsr (.CLOCK_50(CLOCK_50), .reset(reset), .en(!pausa), .q(lfsr));
  assign unused_lfsr = ^lfsr;
  assign offset = RANDOMIZE ? lfsr[2:0] : 3'd0;
  assign start = EW'((32'(ptr_q) + 32'(offset)) % N_ENEMIES);
  always_comb begin
    pop = '0;
    for (int i = 0; i < N_ENEMIES; i++) pop = pop + PW'(alive[i]);
  end
  // shorter cooldown the more enemies are dead, floored at MIN_PERIOD without ever going negative
  assign dead = 32'(N_ENEMIES) - 32'(pop);
  assign period = (32'(FIRE_PERIOD) >= 32'(MIN_PERIOD) + dead) ? CW'(32'(FIRE_PERIOD) - dead) : CW'(MIN_PERIOD);
  assign any_free = ~&slot_busy;
  always_comb begin
    free_idx = '0;
    for (int j = N_SLOTS - 1; j >= 0; j--) if (!slot_busy[j]) free_idx = SW'(j);
  end
  always_comb begin
    state_d = state_q;
    cd_d = cd_q;
    ptr_d = ptr_q;
    scan_d = scan_q;
    cnt_d = cnt_q;
    enemy_d = enemy_q;
    slot_d = slot_q;
    wclear_d = 1'b0;
    fire_valid = state_q == ST_ISSUE && !pausa;
    if (perdeu) begin
      state_d = ST_COOLDOWN;
      cd_d = CW'(FIRE_PERIOD);
    end else if (!pausa) begin
      case (state_q)
        ST_COOLDOWN:
          if (cd_q == '0 && any_free) begin
            slot_d = free_idx;
            scan_d = start;
            cnt_d = '0;
            state_d = ST_SCAN;
          end else if (frame_tick && cd_q != '0) cd_d = cd_q - CW'(1);
        ST_SCAN:
          if (alive[scan_q]) begin
            enemy_d = scan_q;
            state_d = ST_ISSUE;
          end else if (cnt_q == EW'(N_ENEMIES - 1)) begin
            wclear_d = 1'b1;
            cd_d = period;
            state_d = ST_COOLDOWN;
          end else begin
            scan_d = scan_q == EW'(N_ENEMIES - 1) ? '0 : scan_q + EW'(1);
            cnt_d = cnt_q + EW'(1);
          end
        ST_ISSUE:
          if (fire_ready) begin
            ptr_d = enemy_q == EW'(N_ENEMIES - 1) ? '0 : enemy_q + EW'(1);
            cd_d = period;
            state_d = ST_COOLDOWN;
          end
        default: state_d = ST_COOLDOWN;
      endcase
    end
  end
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      state_q <= ST_COOLDOWN;
      cd_q <= CW'(FIRE_PERIOD);
      ptr_q <= '0;
      scan_q <= '0;
      cnt_q <= '0;
      enemy_q <= '0;
      slot_q <= '0;
      wclear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cd_q <= cd_d;
      ptr_q <= ptr_d;
      scan_q <= scan_d;
      cnt_q <= cnt_d;
      enemy_q <= enemy_d;
      slot_q <= slot_d;
      wclear_q <= wclear_d;
    end
  assign fire_enemy = enemy_q;
  assign fire_slot = slot_q;
  assign wave_clear = wclear_q;
endmodule

// File: tb/tb_enemy_fire_scheduler.sv
// tb_enemy_fire_scheduler: directed and random stimulus checked against a behavioural shot model
module tb_enemy_fire_scheduler;
  localparam int N = 20;
  localparam int S = 4;
  localparam int FP = 4;
  localparam int MP = 2;
  logic clk = 0, rst = 1, pausa = 0, perdeu = 0, frame_tick = 0, fire_ready = 1;
  logic [N-1:0] alive = '1;
  logic [S-1:0] slot_busy = '0;
  logic fire_valid, wave_clear;
  logic [4:0] fire_enemy;
  logic [1:0] fire_slot;
  int n_chk = 0, n_fail = 0, n_acc = 0;
  int m_mode = 0, m_cd = FP, m_ptr = 0, m_start = 0, m_k = 0, m_en = 0, m_sl = 0;
  bit m_wc = 0;
  always #5 clk = ~clk;
  enemy_fire_scheduler #(.N_ENEMIES(N), .N_SLOTS(S), .FIRE_PERIOD(FP), .MIN_PERIOD(MP), .RANDOMIZE(1'b0)) dut (
    .CLOCK_50(clk), .reset(rst), .pausa(pausa), .perdeu(perdeu), .frame_tick(frame_tick),
    .alive(alive), .slot_busy(slot_busy), .fire_valid(fire_valid), .fire_ready(fire_ready),
    .fire_enemy(fire_enemy), .fire_slot(fire_slot), .wave_clear(wave_clear)
  );
  function automatic int period_of(input logic [N-1:0] a);
    int d = N - $countones(a);
    return (FP - d < MP) ? MP : FP - d;
  endfunction
  function automatic int first_free(input logic [S-1:0] b);
    for (int j = 0; j < S; j++) if (!b[j]) return j;
    return 0;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // Model: waiting (0) counts frames down, searching (1) walks enemies from the pointer, offering (2) holds the shot
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode <= 0; m_cd <= FP; m_ptr <= 0; m_en <= 0; m_sl <= 0; m_wc <= 0;
    end else begin
      m_wc <= 0;
      if (perdeu) begin
        m_mode <= 0; m_cd <= FP;
      end else if (!pausa) begin
        if (m_mode == 0) begin
          if (m_cd == 0 && slot_busy != '1) begin
            m_sl <= first_free(slot_busy); m_start <= m_ptr; m_k <= 0; m_mode <= 1;
          end else if (frame_tick && m_cd > 0) m_cd <= m_cd - 1;
        end else if (m_mode == 1) begin
          if (alive[(m_start + m_k) % N]) begin
            m_en <= (m_start + m_k) % N; m_mode <= 2;
          end else if (m_k == N - 1) begin
            m_wc <= 1; m_cd <= period_of(alive); m_mode <= 0;
          end else m_k <= m_k + 1;
        end else if (fire_ready) begin
          m_ptr <= (m_en + 1) % N; m_cd <= period_of(alive); m_mode <= 0;
        end
      end
    end
  end
  always @(posedge clk) if (!rst && fire_valid && fire_ready) n_acc <= n_acc + 1;
  always @(negedge clk) begin
    chk("valid", 32'(fire_valid), 32'(m_mode == 2 && !pausa));
    chk("enemy", 32'(fire_enemy), m_en);
    chk("slot", 32'(fire_slot), m_sl);
    chk("wave_clear", 32'(wave_clear), 32'(m_wc));
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic tick(input int n);
    frame_tick = 1;
    cyc(n);
    frame_tick = 0;
  endtask
  task automatic no_valid(input string nm, input int n);
    repeat (n) begin
      chk(nm, 32'(fire_valid), 0);
      cyc(1);
    end
  endtask
  task automatic wait_valid(input string nm, input int budget, output int waited);
    waited = 0;
    while (!fire_valid && waited < budget) begin
      cyc(1);
      waited++;
    end
    chk(nm, 32'(fire_valid), 1);
  endtask
  initial begin
    int w, acc0, n, seen;
    cyc(2);
    chk("rst_valid", 32'(fire_valid), 0);
    chk("rst_enemy", 32'(fire_enemy), 0);
    chk("rst_slot", 32'(fire_slot), 0);
    chk("rst_wclear", 32'(wave_clear), 0);
    rst = 0;
    tick(4);
    wait_valid("t1_fire", 5, w);
    chk("t1_latency", w, 2);
    chk("t1_enemy", 32'(fire_enemy), 0);
    chk("t1_slot", 32'(fire_slot), 0);
    cyc(1);
    chk("t1_one_cycle", 32'(fire_valid), 0);
    tick(4);
    wait_valid("t1_fire2", 5, w);
    chk("t1_enemy2", 32'(fire_enemy), 1);
    cyc(1);
    alive = 20'h00010;
    slot_busy = 4'b0011;
    tick(4);
    wait_valid("t2_fire", 30, w);
    chk("t2_latency", w, 4);
    chk("t2_enemy", 32'(fire_enemy), 4);
    chk("t2_slot", 32'(fire_slot), 2);
    cyc(1);
    tick(1);
    no_valid("t2_reload_hold", 10);
    tick(1);
    wait_valid("t2_reload_fire", 30, w);
    chk("t2_wrap_latency", w, 21);
    chk("t2_enemy_again", 32'(fire_enemy), 4);
    cyc(1);
    alive = '0;
    tick(2);
    n = 0;
    seen = 0;
    while (!wave_clear && n <= 40) begin
      cyc(1);
      n++;
      if (fire_valid) seen = 1;
    end
    chk("t3_wclear_cycle", n, 21);
    chk("t3_no_fire", seen, 0);
    cyc(1);
    chk("t3_wclear_pulse", 32'(wave_clear), 0);
    alive = '1;
    slot_busy = 4'hF;
    fire_ready = 0;
    tick(2);
    no_valid("t4_all_busy", 10);
    slot_busy = 4'b1011;
    wait_valid("t4_fire", 10, w);
    chk("t4_slot", 32'(fire_slot), 2);
    chk("t4_enemy", 32'(fire_enemy), 5);
    cyc(2);
    chk("t5_hold_valid", 32'(fire_valid), 1);
    pausa = 1;
    repeat (5) begin
      #2;
      chk("t5_pause_valid", 32'(fire_valid), 0);
      cyc(1);
    end
    pausa = 0;
    #1;
    chk("t5_resume_valid", 32'(fire_valid), 1);
    chk("t5_enemy", 32'(fire_enemy), 5);
    chk("t5_slot", 32'(fire_slot), 2);
    acc0 = n_acc;
    fire_ready = 1;
    cyc(1);
    chk("t5_drop", 32'(fire_valid), 0);
    cyc(5);
    chk("t5_once", n_acc - acc0, 1);
    fire_ready = 0;
    acc0 = n_acc;
    tick(4);
    wait_valid("t6_fire", 5, w);
    chk("t6_enemy", 32'(fire_enemy), 6);
    perdeu = 1;
    cyc(1);
    chk("t6_perdeu_valid", 32'(fire_valid), 0);
    tick(3);
    perdeu = 0;
    tick(3);
    no_valid("t6_cd_reload", 5);
    tick(1);
    wait_valid("t6_refire", 5, w);
    chk("t6_refire_enemy", 32'(fire_enemy), 6);
    #2;
    rst = 1;
    #1;
    chk("t6_async_valid", 32'(fire_valid), 0);
    cyc(1);
    rst = 0;
    chk("t6_rst_enemy", 32'(fire_enemy), 0);
    tick(3);
    no_valid("t6_rst_cd", 5);
    tick(1);
    wait_valid("t6_rst_fire", 5, w);
    chk("t6_ptr0_enemy", 32'(fire_enemy), 0);
    chk("t6_no_shot", n_acc - acc0, 0);
    for (int c = 0; c < 3000; c++) begin
      pausa = ($urandom_range(15) == 0);
      perdeu = ($urandom_range(63) == 0);
      frame_tick = ($urandom_range(2) == 0);
      fire_ready = 1'($urandom_range(1));
      if ($urandom_range(15) == 0) begin
        n = $urandom_range(3);
        alive = n == 0 ? '0 : n == 1 ? '1 : N'($urandom) & N'($urandom);
      end
      if ($urandom_range(7) == 0) slot_busy = S'($urandom);
      rst = ($urandom_range(499) == 0);
      cyc(1);
    end
    rst = 0;
    pausa = 0;
    perdeu = 0;
    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
